// File: rtl/frame_update_sched_pkg.sv
// Shared types and defaults for the frame update scheduler.
// Holds the FSM state encoding and the sprite/timeout sizing constants.
package frame_update_sched_pkg;

  localparam int NUM_SPRITES_DEF = 4;
  localparam int TIMEOUT_CYC_DEF = 1024;

  // A single requester still needs a 1-bit index port.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int GRANT_ID_W = id_width(NUM_SPRITES_DEF);

  typedef enum logic [1:0] {
    IDLE_ST  = 2'd0,
    ARB_ST   = 2'd1,
    ISSUE_ST = 2'd2,
    WAIT_ST  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first pending bit at or after rr_ptr, wrapping.
// Purely combinational; the scheduler registers its results.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    pending,
  input  logic [ID_W-1:0] rr_ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic            any
);

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the loop so no path infers a latch.
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(rr_ptr) + i) % N;
      if (!any && pending[idx]) begin
        any         = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/frame_update_sched.sv
// Per-frame scheduler sharing one mover datapath among NUM_SPRITES requesters,
// with round-robin start point, step timeout and sticky overrun/timeout flags.
module frame_update_sched
  import frame_update_sched_pkg::*;
#(
  parameter int NUM_SPRITES = NUM_SPRITES_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  localparam int ID_W       = id_width(NUM_SPRITES)
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic [NUM_SPRITES-1:0] req,
  input  logic                   step_done,
  input  logic                   clear_err,
  output logic [NUM_SPRITES-1:0] grant,
  output logic [ID_W-1:0]        grant_id,
  output logic                   step_start,
  output logic                   busy,
  output logic                   frameDone,
  output logic                   overrunFlag,
  output logic                   timeoutFlag
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [ID_W-1:0]  PTR_LAST = ID_W'(NUM_SPRITES - 1);

  state_e                 state_q, state_d;
  logic [NUM_SPRITES-1:0] pending_q, pending_d;
  logic [NUM_SPRITES-1:0] grant_q, grant_d;
  logic [ID_W-1:0]        grant_id_q, grant_id_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   step_start_q, step_start_d;
  logic                   busy_q, busy_d;
  logic                   frame_done_q, frame_done_d;
  logic                   overrun_q, overrun_d;
  logic                   timeout_q, timeout_d;

  logic [NUM_SPRITES-1:0] pick_grant;
  logic [ID_W-1:0]        pick_id;
  logic                   pick_any;
  logic                   release_step;
  logic                   set_overrun;
  logic                   set_timeout;

  rr_pick #(
    .N    (NUM_SPRITES),
    .ID_W (ID_W)
  ) u_rr_pick (
    .pending  (pending_q),
    .rr_ptr   (rr_ptr_q),
    .grant    (pick_grant),
    .grant_id (pick_id),
    .any      (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    grant_d      = grant_q;
    grant_id_d   = grant_id_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    step_start_d = 1'b0;
    release_step = 1'b0;
    set_timeout  = 1'b0;
    set_overrun  = startOfFrame && (state_q != IDLE_ST);

    case (state_q)
      IDLE_ST: begin
        if (startOfFrame) begin
          pending_d = req;
          state_d   = ARB_ST;
        end
      end
      ARB_ST: begin
        if (pick_any) begin
          grant_d      = pick_grant;
          grant_id_d   = pick_id;
          cnt_d        = '0;
          step_start_d = 1'b1;
          state_d      = ISSUE_ST;
        end else begin
          rr_ptr_d = (rr_ptr_q == PTR_LAST) ? '0 : rr_ptr_q + 1'b1;
          state_d  = IDLE_ST;
        end
      end
      ISSUE_ST: begin
        if (step_done) release_step = 1'b1;
        else           state_d      = WAIT_ST;
      end
      WAIT_ST: begin
        // A step_done on the final count wins over the timeout.
        if (step_done) begin
          release_step = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          release_step = 1'b1;
          set_timeout  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE_ST;
    endcase

    if (release_step) begin
      pending_d  = pending_q & ~grant_q;
      grant_d    = '0;
      grant_id_d = '0;
      state_d    = ARB_ST;
    end

    overrun_d    = set_overrun | (overrun_q & ~clear_err);
    timeout_d    = set_timeout | (timeout_q & ~clear_err);
    busy_d       = (state_d != IDLE_ST);
    // frameDone is visible during the ARB cycle that finds nothing left.
    frame_done_d = (state_d == ARB_ST) && (pending_d == '0);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop updates from pre-edge values.
    if (!resetN) begin
      state_q      <= IDLE_ST;
      pending_q    <= '0;
      grant_q      <= '0;
      grant_id_q   <= '0;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      step_start_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      grant_q      <= grant_d;
      grant_id_q   <= grant_id_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      step_start_q <= step_start_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign step_start  = step_start_q;
  assign busy        = busy_q;
  assign frameDone   = frame_done_q;
  assign overrunFlag = overrun_q;
  assign timeoutFlag = timeout_q;

endmodule

// File: tb/tb_frame_update_sched.sv
// Scoreboard bench for frame_update_sched: a frame-level model predicts the
// grant order per frame; a monitor pops predictions as the DUT reports events.
module tb_frame_update_sched;

  localparam int N  = 4;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         resetN;
  logic         startOfFrame;
  logic [N-1:0] req;
  logic         mover_done;
  logic         stray_done;
  logic         step_done;
  logic         clear_err;
  logic [N-1:0] grant;
  logic [1:0]   grant_id;
  logic         step_start;
  logic         busy;
  logic         frameDone;
  logic         overrunFlag;
  logic         timeoutFlag;

  assign step_done = mover_done | stray_done;

  frame_update_sched #(
    .NUM_SPRITES (N),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .req          (req),
    .step_done    (step_done),
    .clear_err    (clear_err),
    .grant        (grant),
    .grant_id     (grant_id),
    .step_start   (step_start),
    .busy         (busy),
    .frameDone    (frameDone),
    .overrunFlag  (overrunFlag),
    .timeoutFlag  (timeoutFlag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Frame-level reference: the whole grant order of a frame is known at startOfFrame.
  typedef enum int {EV_GRANT, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       id;
  } ev_t;

  ev_t exp_q[$];
  int  rr_m = 0;

  function automatic void model_frame(input logic [N-1:0] r);
    for (int i = 0; i < N; i++) begin
      int id;
      id = (rr_m + i) % N;
      if (r[id]) exp_q.push_back('{EV_GRANT, id});
    end
    exp_q.push_back('{EV_DONE, 0});
    rr_m = (rr_m + 1) % N;
  endfunction

  int ss_log[$];
  int ss_id_log[$];
  int fd_cyc   = -1;
  int fd_count = 0;

  function automatic int ss_at(input int i);
    if (i < ss_log.size()) return ss_log[i];
    return -1000;
  endfunction

  function automatic int ss_id_at(input int i);
    if (i < ss_id_log.size()) return ss_id_log[i];
    return -1;
  endfunction

  // Monitor: pops the scoreboard on step_start / frameDone, checks grant encoding.
  initial begin
    ev_t          e;
    logic [N-1:0] prev_grant;
    prev_grant = '0;
    forever begin
      @(negedge clk);
      if (resetN) begin
        if (step_start) begin
          ss_log.push_back(cyc);
          ss_id_log.push_back(int'(grant_id));
          check("sb_entry_on_step_start", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_kind_grant", int'(e.kind), int'(EV_GRANT));
            check("sb_grant_id", int'(grant_id), e.id);
            check("sb_grant_onehot", int'(grant), 1 << e.id);
          end
        end
        if (frameDone) begin
          fd_cyc = cyc;
          fd_count++;
          check("sb_entry_on_frame_done", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_kind_done", int'(e.kind), int'(EV_DONE));
          end
        end
        if (grant != '0) check("grant_matches_id", int'(grant), 1 << grant_id);
        else             check("grant_id_zero_when_idle", int'(grant_id), 0);
        if (grant != '0 && prev_grant != '0 && !step_start)
          check("grant_stable", int'(grant), int'(prev_grant));
      end
      prev_grant = grant;
    end
  end

  // Mover model: answers each step_start after a delay unless the sprite is silent.
  int mover_delay = 5;
  bit mover_rand  = 1'b0;
  int silent_id   = -1;
  int gen         = 0;

  initial begin
    int g;
    int d;
    mover_done = 1'b0;
    forever begin
      @(negedge clk);
      if (resetN && step_start && int'(grant_id) != silent_id) begin
        g = gen;
        d = mover_rand ? int'($urandom_range(0, 6)) : mover_delay;
        repeat (d) begin
          @(posedge clk);
          #1;
        end
        if (gen == g) begin
          mover_done = 1'b1;
          @(posedge clk);
          #1;
          mover_done = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int sof_cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [N-1:0] r);
    model_frame(r);
    sof_cyc      = cyc;
    startOfFrame = 1'b1;
    req          = r;
    tick();
    startOfFrame = 1'b0;
    req          = N'($urandom_range(0, 15));
  endtask

  task automatic wait_frame(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (exp_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    check({name, "_completes"}, int'(done), 1);
  endtask

  task automatic wait_ss(input int n);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ss_log.size() >= n) begin
        done = 1'b1;
        break;
      end
    end
    check("step_start_arrives", int'(done), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"},       int'(grant),       0);
    check({tag, "_grant_id"},    int'(grant_id),    0);
    check({tag, "_step_start"},  int'(step_start),  0);
    check({tag, "_busy"},        int'(busy),        0);
    check({tag, "_frame_done"},  int'(frameDone),   0);
    check({tag, "_overrun"},     int'(overrunFlag), 0);
    check({tag, "_timeout"},     int'(timeoutFlag), 0);
  endtask

  initial begin
    int base;
    int fd0;
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    req          = '0;
    clear_err    = 1'b0;
    stray_done   = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    resetN = 1'b1;
    tick();

    // Frame A: req 1011 from pointer 0 -> 0, 1, 3; done 5 cycles after each start.
    base = ss_log.size();
    start_frame(4'b1011);
    wait_frame("frame_a");
    check("a_start_latency", ss_at(base) - sof_cyc, 2);
    check("a_step_spacing", ss_at(base + 1) - ss_at(base), 7);

    // Frame B: req 1111 from pointer 1 -> 1, 2, 3, 0.
    start_frame(4'b1111);
    wait_frame("frame_b");

    // Frame T: sprite 2 never answers; 16 WAIT cycles then sprite 3 is served.
    silent_id = 2;
    base = ss_log.size();
    start_frame(4'b1100);
    wait_frame("frame_t");
    check("t_timeout_flag", int'(timeoutFlag), 1);
    check("t_release_spacing", ss_at(base + 1) - ss_at(base), TO + 2);
    check("t_next_served", ss_id_at(base + 1), 3);
    check("t_no_overrun", int'(overrunFlag), 0);
    silent_id = -1;

    // Frame O: startOfFrame during WAIT together with clear_err.
    base = ss_log.size();
    fd0  = fd_count;
    start_frame(4'b1111);
    wait_ss(base + 1);
    startOfFrame = 1'b1;
    req          = 4'b0001;
    clear_err    = 1'b1;
    tick();
    startOfFrame = 1'b0;
    clear_err    = 1'b0;
    check("o_overrun_beats_clear", int'(overrunFlag), 1);
    check("o_timeout_cleared", int'(timeoutFlag), 0);
    wait_frame("frame_o");
    check("o_single_frame_done", fd_count - fd0, 1);

    // Frame Z: empty request still completes one cycle after startOfFrame.
    base = ss_log.size();
    start_frame(4'b0000);
    wait_frame("frame_z");
    check("z_done_latency", fd_cyc - sof_cyc, 1);
    check("z_no_step_start", ss_log.size() - base, 0);

    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("clear_overrun", int'(overrunFlag), 0);

    // Frame R: reset while waiting on the mover.
    base = ss_log.size();
    start_frame(4'b1111);
    wait_ss(base + 1);
    tick();
    resetN = 1'b0;
    gen++;
    tick();
    check_all_zero("mid_step_reset");
    exp_q.delete();
    rr_m   = 0;
    resetN = 1'b1;
    repeat (3) tick();
    base = ss_log.size();
    start_frame(4'b1111);
    wait_frame("frame_after_reset");
    check("after_reset_first_grant", ss_id_at(base), 0);

    // Random frames with random mover latency and stray step_done in IDLE.
    mover_rand = 1'b1;
    repeat (30) begin
      if ($urandom_range(0, 2) == 0) begin
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
      end
      start_frame(N'($urandom_range(0, 15)));
      wait_frame("rand_frame");
    end

    check("sb_drained", exp_q.size(), 0);
    check("final_no_timeout", int'(timeoutFlag), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_update_sched.md
FRAME_UPDATE_SCHED -- requirements
Module: frame_update_sched

Interface
REQ-001 Parameter NUM_SPRITES, default 4: number of requesters sharing the single position-update (mover) datapath.
REQ-002 Parameter TIMEOUT_CYC, default 1024: the maximum number of cycles in WAIT_ST before a step is aborted.
REQ-003 clk  input  1  single system clock; all state SHALL be updated on its rising edge.
REQ-004 resetN  input  1  reset, synchronous and active-low.
REQ-005 startOfFrame  input  1  one-cycle pulse at the start of each frame.
REQ-006 req  input  NUM_SPRITES  per-sprite update request, sampled only at the accepted startOfFrame.
REQ-007 step_done  input  1  one-cycle pulse from the mover: the granted sprite's update is complete.
REQ-008 clear_err  input  1  clears the sticky error flags.
REQ-009 grant  output  NUM_SPRITES  one-hot select of the sprite currently owning the mover; all-zero when none.
REQ-010 grant_id  output  log2(NUM_SPRITES)  binary index of the granted sprite; 0 when no grant.
REQ-011 step_start  output  1  one-cycle pulse that launches the mover for the granted sprite.
REQ-012 busy  output  1  high in every state except IDLE_ST.
REQ-013 frameDone  output  1  one-cycle pulse when all latched requests of a frame have been served.
REQ-014 overrunFlag  output  1  sticky: startOfFrame arrived while busy.
REQ-015 timeoutFlag  output  1  sticky: a step exceeded TIMEOUT_CYC.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 The FSM SHALL have exactly four states: IDLE_ST, ARB_ST, ISSUE_ST and WAIT_ST.
REQ-018 IDLE_ST: when startOfFrame=1, the block SHALL latch req into pending and go to ARB_ST on the next cycle.
REQ-019 ARB_ST, pending nonzero: the block SHALL select the first pending bit at or after rr_ptr (wrapping modulo NUM_SPRITES), drive grant/grant_id, and go to ISSUE_ST.
REQ-020 ARB_ST, pending zero: the block SHALL pulse frameDone, advance rr_ptr by 1 (modulo NUM_SPRITES), and go to IDLE_ST.
REQ-021 ISSUE_ST: step_start SHALL be 1 for exactly this one cycle, and the next state SHALL be WAIT_ST.
REQ-022 Latency SHALL be: startOfFrame at cycle t, then ARB at t+1, then step_start with a valid grant at t+2.
REQ-023 grant/grant_id SHALL remain stable throughout ISSUE_ST and WAIT_ST.
REQ-024 step_done in ISSUE_ST or WAIT_ST SHALL clear the granted pending bit, zero grant, and go to ARB_ST on the next cycle.
REQ-025 step_done in IDLE_ST or ARB_ST SHALL be ignored.
REQ-026 The timeout counter SHALL clear on entry to ISSUE_ST and increment every cycle in WAIT_ST.
REQ-027 When the timeout counter reaches TIMEOUT_CYC-1 without step_done, the block SHALL set timeoutFlag, clear the granted pending bit, zero grant, and go to ARB_ST.
REQ-028 If step_done and timeout occur in the same cycle, step_done SHALL win and timeoutFlag SHALL NOT be set.
REQ-029 startOfFrame outside IDLE_ST SHALL set overrunFlag, SHALL NOT be latched, and SHALL NOT disturb the current frame.
REQ-030 A frame whose latched req is all-zero SHALL still produce frameDone at t+1 and advance rr_ptr.
REQ-031 clear_err SHALL zero both flags on the next cycle; a flag-set event in the same cycle SHALL take priority over clear_err.
REQ-032 Each sprite SHALL be granted at most once per frame.

Reset
REQ-033 When resetN=0 at a clock edge, the block SHALL set state=IDLE_ST, pending=0, rr_ptr=0, timeout counter=0, and drive all outputs to 0.
REQ-034 Reset asserted mid-step SHALL abandon the step with no flag set; the first accepted startOfFrame after reset SHALL begin arbitration from sprite 0.

Structure
REQ-035 A shared package SHALL hold the state enum, the NUM_SPRITES default, the TIMEOUT_CYC default, and the grant_id width constant.
REQ-036 The design SHALL use one combinational sub-module, rr_pick (inputs pending and rr_ptr; outputs a one-hot grant, its index, and an any-pending bit).

Verification
REQ-037 Scenario: req=4'b1011, rr_ptr=0, step_done 5 cycles after each step_start -> grants in order 0, 1, 3; frameDone follows; rr_ptr=1.
REQ-038 Scenario: second frame, req=4'b1111 -> grants in order 1, 2, 3, 0.
REQ-039 Scenario: TIMEOUT_CYC=16, mover silent on sprite 2 -> grant released after 16 WAIT cycles; timeoutFlag=1; the next pending sprite is served.
REQ-040 Scenario: startOfFrame during WAIT_ST -> overrunFlag=1; grant sequence unchanged; no extra frameDone.
REQ-041 Scenario: req=0 -> frameDone exactly 1 cycle after startOfFrame; step_start never asserted.
REQ-042 Scenario: resetN=0 during WAIT_ST -> all outputs 0 next cycle; next frame arbitration starts at sprite 0.
